// File: rtl/cm_sketch_pkg.sv
// -----------------------------------------------------------------------------
// cm_sketch_pkg
//   Shared types and default sizing for the count-min lookup scheduler.
//   - sched_state_e : scheduler FSM states (RUN, DRAIN, CLEAR)
//   - sched_tag_t   : per-query tag held in the in-order tag FIFO
//   - SCHED_*       : default parameter values and widths derived from them
// Build option: CM_SCHED_ADDR_CHECK_EN adds the query address to the tag so
// that returning responses can be cross-checked against the issued address.
// -----------------------------------------------------------------------------
package cm_sketch_pkg;

  localparam int SCHED_NUM_REQ   = 4;
  localparam int SCHED_W         = 4096;
  localparam int SCHED_ADDR_SIZE = 22;
  localparam int SCHED_CNT_SIZE  = 32;
  localparam int SCHED_TAG_DEPTH = 8;

  // Client-id and clear-index widths derived from the client count / columns.
  localparam int SCHED_ID_W  = (SCHED_NUM_REQ > 1) ? $clog2(SCHED_NUM_REQ) : 1;
  localparam int SCHED_IDX_W = (SCHED_W > 1) ? $clog2(SCHED_W) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } sched_state_e;

  // The tag is sized from the package defaults; instances must keep NUM_REQ
  // and ADDR_SIZE at the package values so the tag fields line up.
  typedef struct packed {
    logic [SCHED_ID_W-1:0]      id;
`ifdef CM_SCHED_ADDR_CHECK_EN
    logic [SCHED_ADDR_SIZE-1:0] addr;
`endif
  } sched_tag_t;

endpackage

// File: rtl/cm_sched_rr_arb.sv
// -----------------------------------------------------------------------------
// cm_sched_rr_arb
//   Combinational round-robin arbiter. The search starts at the client after
//   ptr and wraps, so the client that won last has the lowest priority.
// Ports:
//   req     in  NUM_REQ  request vector
//   en      in  1        grant enable; when low no grant is produced
//   ptr     in  ID_W     id of the last winner
//   gnt     out NUM_REQ  one-hot grant (all zero when nothing wins)
//   win_id  out ID_W     binary id of the winner
//   win_vld out 1        a grant was produced
// -----------------------------------------------------------------------------
module cm_sched_rr_arb
  import cm_sketch_pkg::*;
#(
  parameter int NUM_REQ = SCHED_NUM_REQ,
  parameter int ID_W    = SCHED_ID_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    win_id,
  output logic               win_vld
);

  always_comb begin
    int cand;
    gnt     = '0;
    win_id  = '0;
    win_vld = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (en && !win_vld && req[cand]) begin
        win_vld   = 1'b1;
        gnt[cand] = 1'b1;
        win_id    = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cm_sketch_min_scheduler.sv
// -----------------------------------------------------------------------------
// cm_sketch_min_scheduler
//   Shares one count-min lookup path between NUM_REQ query clients. A
//   round-robin arbiter grants one query per cycle, each granted query is
//   tagged in an in-order FIFO, and each min result coming back from the
//   lookup path is routed to the client at the FIFO head. A full counter clear
//   (column sweep 0..W-1) runs after reset and on clear_req, after all
//   outstanding queries have returned; no queries are granted meanwhile.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/addr    per-client query (client i at [i*ADDR_SIZE +: ADDR_SIZE])
//   req_ready         one-hot grant, combinational
//   issue_valid/addr  registered query towards the lookup path
//   rsp_valid/addr/cnt  result from the min pipeline
//   res_valid/res_cnt registered per-client result strobe + shared count bus
//   clear_req         request a full counter clear (honoured in RUN only)
//   clr_valid/clr_idx counter-clear write strobe and column index
//   busy              high while draining or clearing
//   clear_done        one-cycle pulse when the sweep finishes
//   err_unexp         sticky: response arrived with nothing outstanding
//   err_addr          sticky: response address differed from the FIFO head
//                     (only with CM_SCHED_ADDR_CHECK_EN defined)
// Build option: CM_SCHED_ADDR_CHECK_EN (adds err_addr and tag address storage).
// -----------------------------------------------------------------------------
module cm_sketch_min_scheduler
  import cm_sketch_pkg::*;
#(
  parameter int NUM_REQ   = SCHED_NUM_REQ,
  parameter int W         = SCHED_W,
  parameter int ADDR_SIZE = SCHED_ADDR_SIZE,
  parameter int CNT_SIZE  = SCHED_CNT_SIZE,
  parameter int TAG_DEPTH = SCHED_TAG_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           issue_valid,
  output logic [ADDR_SIZE-1:0]           issue_addr,
  input  logic                           rsp_valid,
  input  logic [ADDR_SIZE-1:0]           rsp_addr,
  input  logic [CNT_SIZE-1:0]            rsp_cnt,
  output logic [NUM_REQ-1:0]             res_valid,
  output logic [CNT_SIZE-1:0]            res_cnt,
  input  logic                           clear_req,
  output logic                           clr_valid,
  output logic [$clog2(W)-1:0]           clr_idx,
  output logic                           busy,
  output logic                           clear_done,
`ifdef CM_SCHED_ADDR_CHECK_EN
  output logic                           err_addr,
`endif
  output logic                           err_unexp
);

  localparam int ID_W   = SCHED_ID_W;
  localparam int PTR_W  = $clog2(TAG_DEPTH);
  localparam int OCNT_W = PTR_W + 1;
  localparam int IDX_W  = $clog2(W);

  // Control state
  sched_state_e         state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [OCNT_W-1:0]    outstanding_q, outstanding_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;

  // Registered outputs
  logic                 issue_valid_q, issue_valid_d;
  logic [ADDR_SIZE-1:0] issue_addr_q, issue_addr_d;
  logic [NUM_REQ-1:0]   res_valid_q, res_valid_d;
  logic [CNT_SIZE-1:0]  res_cnt_q, res_cnt_d;
  logic                 clr_valid_q, clr_valid_d;
  logic [IDX_W-1:0]     clr_idx_q, clr_idx_d;
  logic                 busy_q, busy_d;
  logic                 clear_done_q, clear_done_d;
  logic                 err_unexp_q, err_unexp_d;
`ifdef CM_SCHED_ADDR_CHECK_EN
  logic                 err_addr_q, err_addr_d;
`endif

  // Tag FIFO storage (data only, not reset)
  sched_tag_t           tag_mem_q [TAG_DEPTH];
  sched_tag_t           push_tag;
  sched_tag_t           head_tag;

  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      win_id;
  logic                 win_vld;
  logic                 grant_en;
  logic [ADDR_SIZE-1:0] win_addr;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;

  // Grants use the registered outstanding count, so a response popping in the
  // same cycle cannot open a slot until the following cycle.
  assign grant_en   = (state_q == RUN) && (outstanding_q < OCNT_W'(TAG_DEPTH));
  assign fifo_empty = (outstanding_q == '0);

  cm_sched_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (req_valid),
    .en      (grant_en),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .win_id  (win_id),
    .win_vld (win_vld)
  );

  assign req_ready = gnt;
  assign push      = win_vld;
  assign pop       = rsp_valid && !fifo_empty;
  assign win_addr  = req_addr[int'(win_id)*ADDR_SIZE +: ADDR_SIZE];
  assign head_tag  = tag_mem_q[rd_ptr_q];

  always_comb begin
    push_tag    = '0;
    push_tag.id = win_id;
`ifdef CM_SCHED_ADDR_CHECK_EN
    push_tag.addr = win_addr;
`endif
  end

`ifndef CM_SCHED_ADDR_CHECK_EN
  // Without the address check the returned address carries no information.
  logic rsp_addr_unused;
  assign rsp_addr_unused = ^rsp_addr;
`endif

  // Grant / tag FIFO / result routing
  always_comb begin
    rr_ptr_d      = push ? win_id : rr_ptr_q;
    wr_ptr_d      = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d      = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    outstanding_d = outstanding_q;
    case ({push, pop})
      2'b10:   outstanding_d = outstanding_q + OCNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OCNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    issue_valid_d = push;
    issue_addr_d  = push ? win_addr : issue_addr_q;

    res_valid_d = '0;
    res_cnt_d   = res_cnt_q;
    if (pop) begin
      res_valid_d[head_tag.id] = 1'b1;
      res_cnt_d                = rsp_cnt;
    end

    // A response with nothing outstanding is dropped and flagged.
    err_unexp_d = err_unexp_q | (rsp_valid & fifo_empty);
`ifdef CM_SCHED_ADDR_CHECK_EN
    err_addr_d  = err_addr_q | (pop && (head_tag.addr != rsp_addr));
`endif
  end

  // Scheduler FSM next state and clear sequencer
  always_comb begin
    state_d      = state_q;
    clr_valid_d  = 1'b0;
    clr_idx_d    = clr_idx_q;
    clear_done_d = 1'b0;
    case (state_q)
      RUN: begin
        if (clear_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d     = CLEAR;
          clr_valid_d = 1'b1;
          clr_idx_d   = '0;
        end
      end
      CLEAR: begin
        if (clr_idx_q == IDX_W'(W - 1)) begin
          state_d      = RUN;
          clr_idx_d    = '0;
          clear_done_d = 1'b1;
        end else begin
          clr_valid_d = 1'b1;
          clr_idx_d   = clr_idx_q + IDX_W'(1);
        end
      end
      default: state_d = DRAIN;
    endcase
    busy_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= DRAIN;
      rr_ptr_q      <= ID_W'(NUM_REQ - 1);
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      issue_valid_q <= 1'b0;
      issue_addr_q  <= '0;
      res_valid_q   <= '0;
      res_cnt_q     <= '0;
      clr_valid_q   <= 1'b0;
      clr_idx_q     <= '0;
      busy_q        <= 1'b1;
      clear_done_q  <= 1'b0;
      err_unexp_q   <= 1'b0;
`ifdef CM_SCHED_ADDR_CHECK_EN
      err_addr_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_addr_q  <= issue_addr_d;
      res_valid_q   <= res_valid_d;
      res_cnt_q     <= res_cnt_d;
      clr_valid_q   <= clr_valid_d;
      clr_idx_q     <= clr_idx_d;
      busy_q        <= busy_d;
      clear_done_q  <= clear_done_d;
      err_unexp_q   <= err_unexp_d;
`ifdef CM_SCHED_ADDR_CHECK_EN
      err_addr_q    <= err_addr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= push_tag;
  end

  assign issue_valid = issue_valid_q;
  assign issue_addr  = issue_addr_q;
  assign res_valid   = res_valid_q;
  assign res_cnt     = res_cnt_q;
  assign clr_valid   = clr_valid_q;
  assign clr_idx     = clr_idx_q;
  assign busy        = busy_q;
  assign clear_done  = clear_done_q;
  assign err_unexp   = err_unexp_q;
`ifdef CM_SCHED_ADDR_CHECK_EN
  assign err_addr    = err_addr_q;
`endif

endmodule

// File: tb/tb_cm_sketch_min_scheduler.sv
`timescale 1ns/1ps
module tb_cm_sketch_min_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int W         = 4096;
  localparam int ADDR_SIZE = 22;
  localparam int CNT_SIZE  = 32;
  localparam int TAG_DEPTH = 8;
  localparam int IDX_W     = 12;
  localparam int LAT       = 5;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         issue_valid;
  logic [ADDR_SIZE-1:0]         issue_addr;
  logic                         rsp_valid;
  logic [ADDR_SIZE-1:0]         rsp_addr;
  logic [CNT_SIZE-1:0]          rsp_cnt;
  logic [NUM_REQ-1:0]           res_valid;
  logic [CNT_SIZE-1:0]          res_cnt;
  logic                         clear_req;
  logic                         clr_valid;
  logic [IDX_W-1:0]             clr_idx;
  logic                         busy;
  logic                         clear_done;
  logic                         err_unexp;
`ifdef CM_SCHED_ADDR_CHECK_EN
  logic                         err_addr;
`endif

  always #5 clk = ~clk;

  cm_sketch_min_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .W         (W),
    .ADDR_SIZE (ADDR_SIZE),
    .CNT_SIZE  (CNT_SIZE),
    .TAG_DEPTH (TAG_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .rsp_valid   (rsp_valid),
    .rsp_addr    (rsp_addr),
    .rsp_cnt     (rsp_cnt),
    .res_valid   (res_valid),
    .res_cnt     (res_cnt),
    .clear_req   (clear_req),
    .clr_valid   (clr_valid),
    .clr_idx     (clr_idx),
    .busy        (busy),
    .clear_done  (clear_done),
`ifdef CM_SCHED_ADDR_CHECK_EN
    .err_addr    (err_addr),
`endif
    .err_unexp   (err_unexp)
  );

  typedef struct {
    int                   id;
    logic [ADDR_SIZE-1:0] addr;
  } exp_t;

  exp_t                 exp_q[$];      // expected results, in grant order
  logic [ADDR_SIZE-1:0] iss_exp_q[$];  // expected issue addresses
  logic [ADDR_SIZE-1:0] lb_addr_q[$];  // loop-back model: issued addresses
  int                   lb_t_q[$];     // loop-back model: issue cycle
  logic [ADDR_SIZE-1:0] cli_addr [NUM_REQ];
  int                   checks;
  int                   failures;
  int                   cyc;
  bit                   loop_en;
  logic [NUM_REQ-1:0]   last_ready;
  logic [NUM_REQ-1:0]   last_xfer;

  // One clock cycle: record transfers before the edge, observe after it.
  task automatic tick();
    int                   w;
    exp_t                 e;
    logic [ADDR_SIZE-1:0] a;
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_SIZE +: ADDR_SIZE] = cli_addr[i];
    #2;
    last_ready = req_ready;
    last_xfer  = rst ? '0 : (req_valid & req_ready);
    if (last_xfer != '0) begin
      w = 0;
      for (int i = 0; i < NUM_REQ; i++) if (last_xfer[i]) w = i;
      e.id   = w;
      e.addr = cli_addr[w];
      exp_q.push_back(e);
      iss_exp_q.push_back(cli_addr[w]);
      cli_addr[w] = ADDR_SIZE'($urandom);
    end
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    if (issue_valid !== (last_xfer != '0)) begin
      failures++;
      $display("FAIL issue_valid cyc=%0d got=%b exp=%b", cyc, issue_valid, (last_xfer != '0));
    end
    if (issue_valid === 1'b1) begin
      checks++;
      if (iss_exp_q.size() == 0) begin
        failures++;
        $display("FAIL issue_addr cyc=%0d got=%h exp=none", cyc, issue_addr);
      end else begin
        a = iss_exp_q.pop_front();
        if (issue_addr !== a) begin
          failures++;
          $display("FAIL issue_addr cyc=%0d got=%h exp=%h", cyc, issue_addr, a);
        end
      end
      lb_addr_q.push_back(issue_addr);
      lb_t_q.push_back(cyc);
    end
    if (res_valid !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL res_unexpected cyc=%0d got=%b exp=0000", cyc, res_valid);
      end else begin
        e = exp_q.pop_front();
        if (res_valid !== (4'b0001 << e.id) || res_cnt !== (32'(e.addr) + 32'd7)) begin
          failures++;
          $display("FAIL res_route cyc=%0d got=%b/%h exp=%b/%h", cyc, res_valid, res_cnt,
                   (4'b0001 << e.id), (32'(e.addr) + 32'd7));
        end
      end
    end
    if (loop_en) begin
      if (lb_addr_q.size() > 0 && (cyc - lb_t_q[0]) >= LAT - 1) begin
        rsp_valid = 1'b1;
        rsp_addr  = lb_addr_q.pop_front();
        w         = lb_t_q.pop_front();
        rsp_cnt   = 32'(rsp_addr) + 32'd7;
      end else begin
        rsp_valid = 1'b0;
      end
    end
  endtask

  // One response taken from the head of issued queries, driven for one cycle.
  task automatic manual_rsp();
    int t;
    rsp_valid = 1'b1;
    rsp_addr  = lb_addr_q.pop_front();
    t         = lb_t_q.pop_front();
    rsp_cnt   = 32'(rsp_addr) + 32'd7;
    tick();
    rsp_valid = 1'b0;
  endtask

  // Runs ticks through a clear sweep and reports what it saw.
  task automatic run_sweep(input int budget, output int n_clr, output int idx_bad,
                           output int n_done, output int gnt_busy, output int first_clr,
                           output int busy_bad);
    n_clr = 0; idx_bad = 0; n_done = 0; gnt_busy = 0; first_clr = -1; busy_bad = 0;
    for (int t = 1; t <= budget; t++) begin
      tick();
      if (last_ready !== '0) gnt_busy++;
      if (clr_valid === 1'b1) begin
        if (first_clr < 0) first_clr = t;
        if (clr_idx !== IDX_W'(n_clr)) idx_bad++;
        if (busy !== 1'b1) busy_bad++;
        n_clr++;
      end
      if (clear_done === 1'b1) begin
        n_done++;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
    end
  endtask

  task automatic drain(input int budget);
    req_valid = '0;
    loop_en   = 1'b1;
    for (int t = 0; t < budget && exp_q.size() != 0; t++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    int n_clr, idx_bad, n_done, gnt_busy, first_clr, busy_bad;
    rst = 1'b1; req_valid = '1; clear_req = 1'b0; rsp_valid = 1'b0; loop_en = 1'b0;
    rsp_addr = '0; rsp_cnt = '0;
    repeat (3) tick();
    checks++;
    if ({clr_valid, clear_done, issue_valid, err_unexp} !== 4'b0 || res_valid !== '0 ||
        res_cnt !== '0 || issue_addr !== '0 || clr_idx !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b%b/%b/%h exp=0", clr_valid, clear_done, issue_valid,
               err_unexp, res_valid, res_cnt);
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++;
    if (last_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", last_ready); end
    rst = 1'b0;
    run_sweep(W + 20, n_clr, idx_bad, n_done, gnt_busy, first_clr, busy_bad);
    checks++;
    if (n_clr != W || idx_bad != 0 || first_clr != 1) begin
      failures++;
      $display("FAIL init_sweep got=%0d/%0d/%0d exp=%0d/0/1", n_clr, idx_bad, first_clr, W);
    end
    checks++;
    if (n_done != 1 || busy_bad != 0) begin
      failures++;
      $display("FAIL init_done got=%0d/%0d exp=1/0", n_done, busy_bad);
    end
    checks++;
    if (gnt_busy != 0) begin failures++; $display("FAIL init_no_grant got=%0d exp=0", gnt_busy); end
    req_valid = '0;
    tick();
    checks++;
    if (busy !== 1'b0 || clear_done !== 1'b0 || clr_valid !== 1'b0) begin
      failures++;
      $display("FAIL init_after got=%b%b%b exp=000", busy, clear_done, clr_valid);
    end
  endtask

  task automatic test_back_to_back();
    int exp_g;
    exp_g = 0;
    loop_en = 1'b1;
    req_valid = '1;
    for (int n = 0; n < 24; n++) begin
      tick();
      checks++;
      if (last_ready !== NUM_REQ'(1 << exp_g)) begin
        failures++;
        $display("FAIL rr_grant n=%0d got=%b exp=%b", n, last_ready, NUM_REQ'(1 << exp_g));
      end
      exp_g = (exp_g + 1) % NUM_REQ;
    end
    drain(40);
  endtask

  task automatic test_stall();
    int nx;
    nx = 0;
    loop_en = 1'b0;
    req_valid = '1;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (last_xfer != '0) nx++;
    end
    checks++;
    if (nx != TAG_DEPTH) begin failures++; $display("FAIL stall_grants got=%0d exp=%0d", nx, TAG_DEPTH); end
    checks++;
    if (last_ready !== '0) begin failures++; $display("FAIL stall_ready got=%b exp=0000", last_ready); end
    manual_rsp();
    checks++;
    if (last_ready !== '0) begin failures++; $display("FAIL same_cycle_pop got=%b exp=0000", last_ready); end
    tick();
    checks++;
    if (last_ready === '0) begin failures++; $display("FAIL grant_after_pop got=%b exp=nonzero", last_ready); end
    drain(60);
  endtask

  task automatic test_clear_drain();
    int n_clr, idx_bad, n_done, gnt_busy, first_clr, busy_bad;
    loop_en = 1'b0;
    req_valid = '1;
    repeat (3) tick();
    req_valid = '0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    req_valid = '1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (last_ready !== '0) begin failures++; $display("FAIL drain_no_grant got=%b exp=0000", last_ready); end
    end
    for (int k = 0; k < 3; k++) begin
      manual_rsp();
      checks++;
      if (clr_valid !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL drain_wait k=%0d got=%b%b exp=01", k, clr_valid, busy);
      end
    end
    run_sweep(W + 20, n_clr, idx_bad, n_done, gnt_busy, first_clr, busy_bad);
    checks++;
    if (first_clr != 1) begin failures++; $display("FAIL clear_start got=%0d exp=1", first_clr); end
    checks++;
    if (n_clr != W || idx_bad != 0 || n_done != 1 || busy_bad != 0) begin
      failures++;
      $display("FAIL req_sweep got=%0d/%0d/%0d/%0d exp=%0d/0/1/0", n_clr, idx_bad, n_done, busy_bad, W);
    end
    checks++;
    if (gnt_busy != 0) begin failures++; $display("FAIL sweep_no_grant got=%0d exp=0", gnt_busy); end
    tick();
    checks++;
    if (last_ready === '0) begin failures++; $display("FAIL grant_resume got=%b exp=nonzero", last_ready); end
    drain(60);
  endtask

  task automatic test_unexpected();
    loop_en = 1'b0;
    req_valid = '0;
    tick();
    checks++;
    if (err_unexp !== 1'b0) begin failures++; $display("FAIL unexp_pre got=%b exp=0", err_unexp); end
    rsp_valid = 1'b1; rsp_addr = 22'h1; rsp_cnt = 32'd55;
    tick();
    rsp_valid = 1'b0;
    checks++;
    if (err_unexp !== 1'b1) begin failures++; $display("FAIL unexp_set got=%b exp=1", err_unexp); end
    checks++;
    if (res_valid !== '0) begin failures++; $display("FAIL unexp_nores got=%b exp=0000", res_valid); end
    tick();
    checks++;
    if (err_unexp !== 1'b1) begin failures++; $display("FAIL unexp_sticky got=%b exp=1", err_unexp); end
`ifdef CM_SCHED_ADDR_CHECK_EN
    checks++;
    if (err_addr !== 1'b0) begin failures++; $display("FAIL addr_pre got=%b exp=0", err_addr); end
    cli_addr[2] = 22'h2;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    manual_rsp_bad();
    checks++;
    if (err_addr !== 1'b1) begin failures++; $display("FAIL addr_err got=%b exp=1", err_addr); end
    checks++;
    if (res_valid !== 4'b0100 || res_cnt !== 32'd9) begin
      failures++;
      $display("FAIL addr_deliver got=%b/%h exp=0100/9", res_valid, res_cnt);
    end
`endif
  endtask

`ifdef CM_SCHED_ADDR_CHECK_EN
  // Response for the head query (address 0x2) but carrying address 0x1.
  task automatic manual_rsp_bad();
    logic [ADDR_SIZE-1:0] a;
    int t;
    a = lb_addr_q.pop_front();
    t = lb_t_q.pop_front();
    rsp_valid = 1'b1;
    rsp_addr  = 22'h1;
    rsp_cnt   = 32'(a) + 32'd7;
    tick();
    rsp_valid = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_sweep();
    int n_clr, idx_bad, n_done, gnt_busy, first_clr, busy_bad;
    bit hit;
    hit = 1'b0;
    req_valid = '0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int t = 0; t < 300 && !hit; t++) begin
      tick();
      if (clr_valid === 1'b1 && clr_idx === IDX_W'(100)) hit = 1'b1;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL mid_sweep_reach got=%0d exp=100", clr_idx); end
    rst = 1'b1;
    tick();
    checks++;
    if (clr_valid !== 1'b0 || busy !== 1'b1 || clear_done !== 1'b0 || err_unexp !== 1'b0 ||
        res_valid !== '0 || issue_valid !== 1'b0 || clr_idx !== '0) begin
      failures++;
      $display("FAIL mid_reset_out got=%b%b%b%b idx=%0d exp=0100 idx=0", clr_valid, busy, clear_done,
               err_unexp, clr_idx);
    end
    exp_q.delete(); iss_exp_q.delete(); lb_addr_q.delete(); lb_t_q.delete();
    rst = 1'b0;
    run_sweep(W + 20, n_clr, idx_bad, n_done, gnt_busy, first_clr, busy_bad);
    checks++;
    if (n_clr != W || idx_bad != 0 || first_clr != 1 || n_done != 1) begin
      failures++;
      $display("FAIL resweep got=%0d/%0d/%0d/%0d exp=%0d/0/1/1", n_clr, idx_bad, first_clr, n_done, W);
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    for (int i = 0; i < NUM_REQ; i++) cli_addr[i] = ADDR_SIZE'(i * 1000 + 5);
    req_addr = '0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_clear_drain();
    test_unexpected();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
